axi_pwm_custom_fade: RTL
========================

Name: axi_pwm_custom_fade

Overview:
Upstream stage of the custom PWM LED interface. It produces the four 12-bit duty values (data_channel_0..3) consumed by the PWM output stage. Software-loaded target duties are ramped linearly from the current duty. Duty values change only at PWM period boundaries, so a duty change never truncates a running PWM period. Sits between the AXI register map and the PWM interface, in the pwm_clk domain.

Parameters:
PERIOD_LEN, 4096, PWM period length in pwm_clk cycles; must match the downstream PWM counter span; legal range 2..65536.
FADE_DIV, 4, number of PWM periods per ramp step; legal range 1..256.

Ports:
pwm_clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
load_valid  input  1  one-cycle strobe; captures target_0..3 and step
target_0  input  12  channel 0 target duty
target_1  input  12  channel 1 target duty
target_2  input  12  channel 2 target duty
target_3  input  12  channel 3 target duty
step  input  12  duty increment per ramp step; 0 = jump directly
data_channel_0  output  12  channel 0 duty to the PWM stage (registered)
data_channel_1  output  12  channel 1 duty (registered)
data_channel_2  output  12  channel 2 duty (registered)
data_channel_3  output  12  channel 3 duty (registered)
busy  output  1  high while state is FADING
fade_done  output  1  one-cycle pulse on FADING->IDLE
period_tick  output  1  high in the last cycle of each PWM period

Behaviour:
- Reset (async assert, synchronous release): all data_channel_x = 0; targets, step_q, period_cnt and div_cnt = 0; state IDLE; busy = fade_done = 0.
- period_cnt counts 0..PERIOD_LEN-1 and wraps to 0. period_tick is combinational: period_cnt == PERIOD_LEN-1.
- div_cnt advances on period_tick, counting 0..FADE_DIV-1 and wrapping. fade_tick = period_tick && div_cnt == FADE_DIV-1. Both counters free-run in every state.
- load_valid: at that edge, register target_x into tgt_x and step into step_q, then go to FADING (from any state). Counters are not reset. Inputs are ignored when load_valid is low.
- FSM states:
  - IDLE: outputs held.
  - FADING: on each fade_tick, every channel updates independently.
    - cur < tgt: cur = min(cur + step_q, tgt)
    - cur > tgt: cur = max(cur - step_q, tgt)
    - cur == tgt: hold.
    - step_q == 0: cur = tgt.
    - Arithmetic uses 13 bits internally; no wrap or overshoot is possible.
  - FADING->IDLE: at the fade_tick edge where all four channels equal their tgt_x, either after the update or already before it. fade_done pulses for the cycle following that edge.
- Latency: a new duty appears on data_channel_x the cycle after fade_tick, which is cycle 0 of the next PWM period.
- load_valid on the same edge as fade_tick: the channel update uses the old tgt/step_q; the new values are captured at that edge; state is FADING. The FADING->IDLE exit is suppressed on that edge, so fade_done does not pulse.
- load_valid while FADING: retargets from the current outputs; no discontinuity.
- Load with targets equal to the current outputs: busy stays high until the next fade_tick, then fade_done pulses once.
- busy is high exactly while the state is FADING.
- rst mid-fade: immediate zeroing; no fade_done pulse.

Test Plan:
- Reset sequence (PERIOD_LEN=8, FADE_DIV=2): rst high for 3 cycles then low. data_channel_x=0, busy=0, fade_done=0. period_tick first high at cycle 7 after release and every 8 cycles after that.
- Load tgt0=100, step=40, other targets 0. ch0 goes 40, 80, 100 on successive fade_ticks, each new value visible the cycle after period_tick. Channels 1-3 stay 0. fade_done pulses once after 100 is reached; busy then drops.
- Downward clamp: ch1 at 4095, load tgt1=0, step=1000. ch1 goes 3095, 2095, 1095, 95, 0. No wrap to a large value.
- step=0 with tgt=0xABC on all channels: all four channels equal 0xABC after the first fade_tick, and fade_done pulses.
- Retarget mid-fade: ch0 ramping 0->400 with step 50; at ch0=150 load tgt0=0, step 50. ch0 goes 100, 50, 0, with exactly one fade_done.
- Collision: load_valid asserted in a fade_tick cycle. That step uses the old step/target, the next step uses the new ones, no fade_done in the collision cycle. Separately, rst asserted mid-fade zeroes all outputs asynchronously.

Source files
------------

// File: rtl/axi_pwm_custom_fade.sv
// Four-channel duty ramp generator feeding the PWM output stage.
// load_valid is a one-cycle strobe with no back-pressure: it is accepted on every edge it is high.
module axi_pwm_custom_fade #(
  parameter int PERIOD_LEN = 4096,
  parameter int FADE_DIV   = 4
) (
  input  logic        pwm_clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [11:0] target_0,
  input  logic [11:0] target_1,
  input  logic [11:0] target_2,
  input  logic [11:0] target_3,
  input  logic [11:0] step,
  output logic [11:0] data_channel_0,
  output logic [11:0] data_channel_1,
  output logic [11:0] data_channel_2,
  output logic [11:0] data_channel_3,
  output logic        busy,
  output logic        fade_done,
  output logic        period_tick
);

  localparam int PW = (PERIOD_LEN > 1) ? $clog2(PERIOD_LEN) : 1;
  localparam int DW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_LEN - 1);
  localparam logic [DW-1:0] D_LAST = DW'(FADE_DIV - 1);

  typedef enum logic {IDLE, FADING} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    period_cnt_q, period_cnt_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [3:0][11:0] cur_q, cur_d, tgt_q, tgt_d, nxt;
  logic [11:0]      step_q, step_d;
  logic             fade_done_q, fade_done_d;
  logic             fade_tick, all_eq;

  // One ramp step toward tgt; 13-bit sums so the clamp sees any carry or borrow.
  function automatic logic [11:0] ramp(input logic [11:0] cur, input logic [11:0] tgt,
                                       input logic [11:0] stp);
    logic [12:0] sum;
    logic [12:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = {1'b0, cur} - {1'b0, stp};
    ramp = cur;
    if (stp == 12'd0) begin
      ramp = tgt;
    end else if (cur < tgt) begin
      ramp = (sum >= {1'b0, tgt}) ? tgt : sum[11:0];
    end else if (cur > tgt) begin
      ramp = (diff[12] || (diff[11:0] <= tgt)) ? tgt : diff[11:0];
    end
  endfunction

  always_comb begin
    period_tick  = (period_cnt_q == P_LAST);
    period_cnt_d = period_tick ? '0 : period_cnt_q + 1'b1;
    div_cnt_d    = div_cnt_q;
    if (period_tick) begin
      div_cnt_d = (div_cnt_q == D_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    fade_tick = period_tick && (div_cnt_q == D_LAST);

    all_eq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt[i] = ramp(cur_q[i], tgt_q[i], step_q);
      if (nxt[i] != tgt_q[i]) all_eq = 1'b0;
    end

    state_d     = state_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    fade_done_d = 1'b0;

    if ((state_q == FADING) && fade_tick) begin
      cur_d = nxt;
      // A load on the same edge keeps the fade alive with the new target.
      if (all_eq && !load_valid) begin
        state_d     = IDLE;
        fade_done_d = 1'b1;
      end
    end

    if (load_valid) begin
      tgt_d   = {target_3, target_2, target_1, target_0};
      step_d  = step;
      state_d = FADING;
    end
  end

  always_ff @(posedge pwm_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      period_cnt_q <= '0;
      div_cnt_q    <= '0;
      cur_q        <= '0;
      tgt_q        <= '0;
      step_q       <= '0;
      fade_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      div_cnt_q    <= div_cnt_d;
      cur_q        <= cur_d;
      tgt_q        <= tgt_d;
      step_q       <= step_d;
      fade_done_q  <= fade_done_d;
    end
  end

  assign data_channel_0 = cur_q[0];
  assign data_channel_1 = cur_q[1];
  assign data_channel_2 = cur_q[2];
  assign data_channel_3 = cur_q[3];
  assign busy           = (state_q == FADING);
  assign fade_done      = fade_done_q;

endmodule
